// File: rtl/seq_fixed_point_div.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : seq_fixed_point_div
//  Description : Multi-cycle signed fixed-point divider. Restoring division
//                producing one quotient bit per cycle, with valid/ready
//                handshakes on the operand and result sides. Rounding,
//                saturation and flag behaviour follow the combinational
//                divider with the same parameter set.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_fixed_point_div #(
    parameter int WIIA  = 8,
    parameter int WIFA  = 8,
    parameter int WIIB  = 8,
    parameter int WIFB  = 8,
    parameter int WOI   = 8,
    parameter int WOF   = 8,
    parameter int ROOF  = 1,
    parameter int ROUND = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_valid,
    output logic                  i_ready,
    input  logic [WIIA+WIFA-1:0]  dividend,
    input  logic [WIIB+WIFB-1:0]  divisor,
    output logic                  o_valid,
    input  logic                  o_ready,
    output logic [WOI+WOF-1:0]    out,
    output logic                  upflow,
    output logic                  downflow
);

    localparam int c_WA  = WIIA + WIFA;
    localparam int c_WB  = WIIB + WIFB;
    localparam int c_WO  = WOI + WOF;
    // Quotient carries one extra fraction bit so rounding can be applied.
    localparam int c_QW  = c_WO + 1;
    localparam int c_NSH = WOF + 1 + WIFB;
    localparam int c_NW  = c_WA + c_NSH;
    localparam int c_DW  = c_WB + WIFA;
    // Wide enough for both the scaled dividend and divisor * 2^QW.
    localparam int c_RW  = (c_NW > c_DW + c_QW) ? c_NW : (c_DW + c_QW);
    localparam int c_CW  = $clog2(c_QW);

    localparam logic [c_QW-1:0] c_LIM_NEG = c_QW'(1) << (c_WO - 1);
    localparam logic [c_QW-1:0] c_LIM_POS = c_LIM_NEG - c_QW'(1);
    localparam logic [c_WO-1:0] c_SAT_POS = {1'b0, {(c_WO-1){1'b1}}};
    localparam logic [c_WO-1:0] c_SAT_NEG = {1'b1, {(c_WO-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            r_state;
    logic              r_sign;
    logic              r_a_nz;
    logic              r_dz;
    logic              r_ovf;
    logic [c_WA-1:0]   r_abs_a;
    logic [c_WB-1:0]   r_abs_b;
    logic [c_RW-1:0]   r_rem;
    logic [c_RW-1:0]   r_dsh;
    logic [c_QW-1:0]   r_q;
    logic [c_CW-1:0]   r_cnt;
    logic              r_i_ready;
    logic              r_o_valid;
    logic [c_WO-1:0]   r_out;
    logic              r_up;
    logic              r_dn;

    logic [c_WA-1:0]   w_abs_a;
    logic [c_WB-1:0]   w_abs_b;
    logic [c_RW-1:0]   w_n;
    logic [c_RW-1:0]   w_d;
    logic              w_ovf_ld;
    logic              w_ge;
    logic [c_QW-1:0]   w_mag;
    logic [c_WO-1:0]   w_mag_lo;
    logic [c_WO-1:0]   w_sres;
    logic              w_big;
    logic              w_ovf;
    logic [c_WO-1:0]   w_res;
    logic              w_dn;

    assign w_abs_a  = dividend[c_WA-1] ? -dividend : dividend;
    assign w_abs_b  = divisor[c_WB-1]  ? -divisor  : divisor;
    assign w_n      = c_RW'(r_abs_a) << c_NSH;
    assign w_d      = c_RW'(r_abs_b) << WIFA;
    assign w_ovf_ld = (r_abs_b == '0) || (w_n >= (w_d << c_QW));
    assign w_ge     = (r_rem >= r_dsh);

    // (Q+1)>>1 equals (Q>>1) plus the dropped half bit.
    assign w_mag    = (r_q >> 1) + {{(c_QW-1){1'b0}}, ((ROUND != 0) && r_q[0])};
    assign w_mag_lo = w_mag[c_WO-1:0];
    assign w_sres   = r_sign ? -w_mag_lo : w_mag_lo;
    assign w_big    = r_sign ? (w_mag > c_LIM_NEG) : (w_mag > c_LIM_POS);
    assign w_ovf    = r_ovf || w_big;

    // Final result selection; an early overflow never forms a quotient, so
    // wrap mode has no low bits to keep and reports zero.
    always_comb begin
        w_res = w_sres;
        if (w_ovf) begin
            if (ROOF != 0) begin
                w_res = r_sign ? c_SAT_NEG : c_SAT_POS;
            end else if (r_ovf) begin
                w_res = '0;
            end
        end
        w_dn = r_a_nz && !r_dz && !w_ovf && (w_res == '0);
    end

    // Control FSM and restoring-division datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_sign    <= 1'b0;
            r_a_nz    <= 1'b0;
            r_dz      <= 1'b0;
            r_ovf     <= 1'b0;
            r_abs_a   <= '0;
            r_abs_b   <= '0;
            r_rem     <= '0;
            r_dsh     <= '0;
            r_q       <= '0;
            r_cnt     <= '0;
            r_i_ready <= 1'b1;
            r_o_valid <= 1'b0;
            r_out     <= '0;
            r_up      <= 1'b0;
            r_dn      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_valid && r_i_ready) begin
                        r_sign    <= dividend[c_WA-1] ^ divisor[c_WB-1];
                        r_abs_a   <= w_abs_a;
                        r_abs_b   <= w_abs_b;
                        r_a_nz    <= (dividend != '0);
                        r_i_ready <= 1'b0;
                        r_state   <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_rem   <= w_n;
                    r_dsh   <= w_d << (c_QW - 1);
                    r_q     <= '0;
                    r_dz    <= (r_abs_b == '0);
                    r_ovf   <= w_ovf_ld;
                    r_cnt   <= c_CW'(c_QW - 1);
                    r_state <= w_ovf_ld ? S_DONE : S_DIV;
                end
                S_DIV: begin
                    if (w_ge) begin
                        r_rem <= r_rem - r_dsh;
                    end
                    r_q   <= {r_q[c_QW-2:0], w_ge};
                    r_dsh <= r_dsh >> 1;
                    if (r_cnt == '0) begin
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - c_CW'(1);
                    end
                end
                S_DONE: begin
                    if (!r_o_valid) begin
                        r_o_valid <= 1'b1;
                        r_out     <= w_res;
                        r_up      <= w_ovf;
                        r_dn      <= w_dn;
                    end else if (o_ready) begin
                        r_o_valid <= 1'b0;
                        r_i_ready <= 1'b1;
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign i_ready  = r_i_ready;
    assign o_valid  = r_o_valid;
    assign out      = r_out;
    assign upflow   = r_up;
    assign downflow = r_dn;

endmodule
`default_nettype wire

// File: tb/tb_seq_fixed_point_div.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_seq_fixed_point_div
//  Description : Scoreboard bench for seq_fixed_point_div. A rounding/
//                saturating instance and a truncating/wrapping instance are
//                driven in lockstep and compared against an arithmetic model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_fixed_point_div;

    localparam int P_WIFA = 8;
    localparam int P_WIFB = 8;
    localparam int P_WOF  = 8;
    localparam int P_WO   = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_valid = 1'b0;
    logic [15:0] dividend = '0;
    logic [15:0] divisor = '0;
    logic        o_ready = 1'b0;

    logic        i_ready_r, o_valid_r, up_r, dn_r;
    logic [15:0] out_r;
    logic        i_ready_t, o_valid_t, up_t, dn_t;
    logic [15:0] out_t;

    always #5 clk = ~clk;

    seq_fixed_point_div u_dut_rnd (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(i_ready_r),
        .dividend(dividend), .divisor(divisor), .o_valid(o_valid_r),
        .o_ready(o_ready), .out(out_r), .upflow(up_r), .downflow(dn_r)
    );

    seq_fixed_point_div #(.ROOF(0), .ROUND(0)) u_dut_trn (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(i_ready_t),
        .dividend(dividend), .divisor(divisor), .o_valid(o_valid_t),
        .o_ready(o_ready), .out(out_t), .upflow(up_t), .downflow(dn_t)
    );

    typedef struct {
        logic [15:0] out_r;
        logic        up_r;
        logic        dn_r;
        logic [15:0] out_t;
        logic        up_t;
        logic        dn_t;
        bit          chk_out_t;
        int          lat;
        int          acc;
    } exp_t;

    exp_t q[$];
    int   n_pass = 0;
    int   n_total = 0;
    int   cyc = 0;
    bit   rand_ready = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Reference: exact rational quotient scaled to output units.
    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b);
        exp_t   e;
        longint sa, sb, na, nb, num, den, mr, mt, lim;
        bit     neg, early;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        neg = (sa < 0) ^ (sb < 0);
        na  = (sa < 0) ? -sa : sa;
        nb  = (sb < 0) ? -sb : sb;
        e.chk_out_t = 1'b1;
        e.acc = 0;
        if (nb == 0) begin
            e.out_r = (sa < 0) ? 16'h8000 : 16'h7FFF;
            e.up_r  = 1'b1;
            e.dn_r  = 1'b0;
            e.out_t = 16'h0000;
            e.up_t  = 1'b1;
            e.dn_t  = 1'b0;
            e.lat   = 2;
        end else begin
            num   = na << (P_WOF + P_WIFB);
            den   = nb << P_WIFA;
            mt    = num / den;
            mr    = (2 * num + den) / (2 * den);
            early = (mt >= (longint'(1) << P_WO));
            e.lat = early ? 2 : (P_WO + 1 + 2);
            lim   = neg ? (longint'(1) << (P_WO - 1)) : ((longint'(1) << (P_WO - 1)) - 1);
            e.up_r  = (mr > lim);
            e.out_r = e.up_r ? (neg ? 16'h8000 : 16'h7FFF) : 16'(neg ? -mr : mr);
            e.dn_r  = (sa != 0) && !e.up_r && (e.out_r == 16'h0000);
            e.up_t  = (mt > lim);
            e.out_t = 16'(neg ? -mt : mt);
            e.chk_out_t = !early;
            e.dn_t  = (sa != 0) && !e.up_t && (e.out_t == 16'h0000);
        end
        return e;
    endfunction

    task automatic issue(input logic [15:0] a, input logic [15:0] b);
        int   w;
        exp_t e;
        w = 0;
        @(negedge clk);
        while (!i_ready_r && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!i_ready_r) begin
            check("issue_timeout", i_ready_r, 1);
            return;
        end
        dividend = a;
        divisor  = b;
        i_valid  = 1'b1;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        e = model(a, b);
        e.acc = cyc;
        q.push_back(e);
    endtask

    task automatic drain();
        int w;
        w = 0;
        while ((q.size() != 0 || o_valid_r) && w < 500) begin
            @(negedge clk);
            w++;
        end
        check("drain_queue", q.size(), 0);
    endtask

    // Random downstream backpressure when enabled.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (rand_ready) o_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: compare each presented result once, then verify it is held.
    bit          checked = 1'b0;
    logic [15:0] held_out;
    logic [1:0]  held_flags;
    always @(negedge clk) begin
        if (!rst && (o_valid_r || o_valid_t)) begin
            if (!checked) begin
                if (q.size() == 0) begin
                    check("unexpected_result", o_valid_r, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("valid_lockstep", o_valid_t, o_valid_r);
                    check("latency", cyc - e.acc, e.lat);
                    check("out_rnd", out_r, e.out_r);
                    check("upflow_rnd", up_r, e.up_r);
                    check("downflow_rnd", dn_r, e.dn_r);
                    if (e.chk_out_t) check("out_trn", out_t, e.out_t);
                    check("upflow_trn", up_t, e.up_t);
                    check("downflow_trn", dn_t, e.dn_t);
                end
                held_out   = out_r;
                held_flags = {up_r, dn_r};
                checked    = 1'b1;
            end else begin
                check("hold_out", out_r, held_out);
                check("hold_flags", {up_r, dn_r}, held_flags);
                check("hold_iready", {i_ready_r, i_ready_t}, 0);
            end
            if (o_ready) checked = 1'b0;
        end
    end

    logic [15:0] vec_a [16] = '{16'h0300, 16'h0200, 16'hFE00, 16'h7F00, 16'h8000, 16'h0100,
                                16'hFF00, 16'h0001, 16'h0000, 16'h7FFF, 16'h8000, 16'h0001,
                                16'hFFFF, 16'h8000, 16'h7FFF, 16'h0000};
    logic [15:0] vec_b [16] = '{16'h0200, 16'h0300, 16'h0300, 16'h0080, 16'h0100, 16'h0000,
                                16'h0000, 16'h7F00, 16'h1234, 16'h0001, 16'hFFFF, 16'h0200,
                                16'h0200, 16'hFF00, 16'h0100, 16'h0000};

    initial begin
        logic [15:0] a, b;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_iready", {i_ready_r, i_ready_t}, 2'b11);
        check("reset_ovalid", {o_valid_r, o_valid_t}, 0);
        check("reset_out", {out_r, out_t}, 0);
        check("reset_flags", {up_r, dn_r, up_t, dn_t}, 0);

        rand_ready = 1'b1;
        for (int i = 0; i < 16; i++) issue(vec_a[i], vec_b[i]);
        for (int i = 0; i < 150; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            case ($urandom_range(0, 5))
                0: b = 16'h0000;
                1: b = ($urandom_range(0, 1) != 0) ? 16'($urandom_range(1, 511))
                                                    : -16'($urandom_range(1, 511));
                2: a = 16'h0000;
                default: ;
            endcase
            issue(a, b);
        end
        drain();

        // Backpressure: result must stay put while o_ready is low.
        rand_ready = 1'b0;
        @(posedge clk);
        #1 o_ready = 1'b0;
        issue(16'h0300, 16'h0200);
        begin
            int w;
            w = 0;
            while (!o_valid_r && w < 40) begin
                @(negedge clk);
                w++;
            end
            check("bp_valid_seen", o_valid_r, 1);
        end
        repeat (5) begin
            @(negedge clk);
            check("bp_valid_held", o_valid_r, 1);
            check("bp_iready_low", i_ready_r, 0);
        end
        @(posedge clk);
        #1 o_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_valid_drop", o_valid_r, 0);
        check("bp_iready_back", i_ready_r, 1);
        check("bp_out_kept", out_r, 16'h0180);

        // Reset in the middle of a division discards it.
        issue(16'h0200, 16'h0300);
        repeat (6) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        q.delete();
        check("midrst_ovalid", o_valid_r, 0);
        check("midrst_iready", i_ready_r, 1);
        check("midrst_out", out_r, 0);
        check("midrst_flags", {up_r, dn_r}, 0);
        issue(16'h0300, 16'h0200);
        rand_ready = 1'b1;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
        $fatal(1);
    end

endmodule
`default_nettype wire
